// File: rtl/c66x_power_supervisor.sv
// rtl/c66x_power_supervisor.sv - C66x power/reset sequencer supervisor
// Gates sequencer enable with power-on hold-off, retry back-off and lockout.
module c66x_power_supervisor #(
    parameter int TICK_DIV           = 500,
    parameter int POWERON_TICKS      = 100,
    parameter int BOOT_TIMEOUT_TICKS = 30000,
    parameter int BACKOFF_BASE_TICKS = 250,
    parameter int STABLE_TICKS       = 10000,
    parameter int MAX_RETRIES        = 3
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       host_enable,
    input  logic [3:0] seq_state,
    output logic       seq_enable,
    output logic [2:0] retry_count,
    output logic       locked_out,
    output logic       fault,
    output logic [2:0] sup_state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        ST_POWERON = 3'd0,
        ST_IDLE    = 3'd1,
        ST_BOOTING = 3'd2,
        ST_UP      = 3'd3,
        ST_BACKOFF = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

    state_t      r_state;
    logic [PW-1:0] r_presc;
    logic [15:0] r_timer;
    logic [3:0]  r_sq_s1;
    logic [3:0]  r_sq_s2;
    logic [3:0]  r_sq;
    logic [2:0]  r_retry;
    logic        r_seq_enable;
    logic        r_locked_out;
    logic        r_fault;

    logic        w_tick;
    logic        w_sq_bad;
    logic        w_at_max;
    logic [18:0] w_backoff_shift;
    logic [15:0] w_backoff_lim;

    assign w_tick   = (r_presc == PW'(TICK_DIV - 1));
    assign w_sq_bad = (r_sq >= 4'hA);
    assign w_at_max = (r_retry == 3'(MAX_RETRIES));

    // Shift is wide enough for base << 6; anything past 16 bits waits the full timer range.
    assign w_backoff_shift = 19'(BACKOFF_BASE_TICKS) << (r_retry - 3'd1);
    assign w_backoff_lim   = (|w_backoff_shift[18:16]) ? 16'hFFFF : w_backoff_shift[15:0];

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // The filtered value only moves once both synchroniser stages agree, dropping 1-cycle glitches.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_sq_s1 <= 4'h0;
            r_sq_s2 <= 4'h0;
            r_sq    <= 4'h0;
        end else begin
            r_sq_s1 <= seq_state;
            r_sq_s2 <= r_sq_s1;
            if (r_sq_s1 == r_sq_s2) begin
                r_sq <= r_sq_s2;
            end
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_POWERON;
            r_timer      <= 16'h0000;
            r_retry      <= 3'd0;
            r_seq_enable <= 1'b0;
            r_locked_out <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_fault <= 1'b0;
            if (w_tick && (r_timer != 16'hFFFF)) begin
                r_timer <= r_timer + 16'd1;
            end
            case (r_state)
                ST_POWERON: begin
                    if (r_timer == 16'(POWERON_TICKS)) begin
                        r_state <= ST_IDLE;
                        r_timer <= 16'h0000;
                    end
                end
                ST_IDLE: begin
                    if (host_enable) begin
                        r_state      <= ST_BOOTING;
                        r_timer      <= 16'h0000;
                        r_seq_enable <= 1'b1;
                    end
                end
                ST_BOOTING: begin
                    if (!host_enable) begin
                        r_state      <= ST_IDLE;
                        r_timer      <= 16'h0000;
                        r_retry      <= 3'd0;
                        r_seq_enable <= 1'b0;
                    end else if (r_sq == 4'h9) begin
                        r_state <= ST_UP;
                        r_timer <= 16'h0000;
                    end else if (w_sq_bad || (r_timer == 16'(BOOT_TIMEOUT_TICKS))) begin
                        r_fault      <= 1'b1;
                        r_timer      <= 16'h0000;
                        r_seq_enable <= 1'b0;
                        if (w_at_max) begin
                            r_state      <= ST_LOCKOUT;
                            r_locked_out <= 1'b1;
                        end else begin
                            r_state <= ST_BACKOFF;
                            r_retry <= r_retry + 3'd1;
                        end
                    end
                end
                ST_UP: begin
                    if (!host_enable) begin
                        r_state      <= ST_IDLE;
                        r_timer      <= 16'h0000;
                        r_seq_enable <= 1'b0;
                    end else if (r_sq != 4'h9) begin
                        r_fault      <= 1'b1;
                        r_timer      <= 16'h0000;
                        r_seq_enable <= 1'b0;
                        if (w_at_max) begin
                            r_state      <= ST_LOCKOUT;
                            r_locked_out <= 1'b1;
                        end else begin
                            r_state <= ST_BACKOFF;
                            r_retry <= r_retry + 3'd1;
                        end
                    end else if (r_timer == 16'(STABLE_TICKS)) begin
                        r_retry <= 3'd0;
                    end
                end
                ST_BACKOFF: begin
                    if (!host_enable) begin
                        r_state <= ST_IDLE;
                        r_timer <= 16'h0000;
                    end else if ((r_sq == 4'h0) && (r_timer >= w_backoff_lim)) begin
                        r_state      <= ST_BOOTING;
                        r_timer      <= 16'h0000;
                        r_seq_enable <= 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (!host_enable) begin
                        r_state      <= ST_IDLE;
                        r_timer      <= 16'h0000;
                        r_retry      <= 3'd0;
                        r_locked_out <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_timer      <= 16'h0000;
                    r_seq_enable <= 1'b0;
                    r_locked_out <= 1'b0;
                end
            endcase
        end
    end

    assign seq_enable  = r_seq_enable;
    assign retry_count = r_retry;
    assign locked_out  = r_locked_out;
    assign fault       = r_fault;
    assign sup_state   = r_state;

endmodule

// File: tb/tb_c66x_power_supervisor.sv
// tb/tb_c66x_power_supervisor.sv - directed self-checking bench for c66x_power_supervisor
module tb_c66x_power_supervisor;

    logic       sysclk;
    logic       reset;
    logic       host_enable;
    logic [3:0] seq_state;
    logic       seq_enable;
    logic [2:0] retry_count;
    logic       locked_out;
    logic       fault;
    logic [2:0] sup_state;

    int checks = 0;
    int errors = 0;
    int fault_cnt = 0;

    c66x_power_supervisor #(
        .TICK_DIV(4),
        .POWERON_TICKS(5),
        .BOOT_TIMEOUT_TICKS(50),
        .BACKOFF_BASE_TICKS(8),
        .STABLE_TICKS(20),
        .MAX_RETRIES(3)
    ) dut (
        .sysclk(sysclk),
        .reset(reset),
        .host_enable(host_enable),
        .seq_state(seq_state),
        .seq_enable(seq_enable),
        .retry_count(retry_count),
        .locked_out(locked_out),
        .fault(fault),
        .sup_state(sup_state)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    always @(negedge sysclk) begin
        if (fault === 1'b1) fault_cnt++;
    end

    task automatic step();
        @(negedge sysclk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        checks++;
        assert (((obs >= lo) && (obs <= hi)) === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    task automatic wait_se(input int max, output int n);
        n = 0;
        while ((seq_enable !== 1'b1) && (n <= max)) begin
            step();
            n++;
        end
    endtask

    task automatic wait_fault(input int max, output int n);
        n = 0;
        while ((fault !== 1'b1) && (n <= max)) begin
            step();
            n++;
        end
    endtask

    initial begin
        int n;
        int fc0;
        logic se_early;

        reset = 1'b1;
        host_enable = 1'b1;
        seq_state = 4'h0;
        repeat (3) step();
        reset = 1'b0;

        check("rst_seq_enable", 32'(seq_enable), 32'd0);
        check("rst_sup_state", 32'(sup_state), 32'd0);
        check("rst_retry", 32'(retry_count), 32'd0);
        check("rst_locked", 32'(locked_out), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);

        // Power-on hold-off: 5 ticks of 4 cycles, then IDLE, then BOOTING
        se_early = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (seq_enable === 1'b1) se_early = 1'b1;
        end
        check("po_no_early_enable", 32'(se_early), 32'd0);
        check("po_state_c20", 32'(sup_state), 32'd0);
        step();
        check("po_state_c21", 32'(sup_state), 32'd1);
        check("po_se_c21", 32'(seq_enable), 32'd0);
        step();
        check("po_state_c22", 32'(sup_state), 32'd2);
        check("po_se_c22", 32'(seq_enable), 32'd1);

        // Normal boot ramp; UP four edges after 9 is applied
        fc0 = fault_cnt;
        for (int v = 1; v <= 8; v++) begin
            seq_state = 4'(v);
            step();
        end
        seq_state = 4'h9;
        repeat (3) step();
        check("boot_state_pre", 32'(sup_state), 32'd2);
        step();
        check("boot_state_up", 32'(sup_state), 32'd3);
        step();
        check("boot_no_fault", 32'(fault_cnt - fc0), 32'd0);
        check("boot_retry", 32'(retry_count), 32'd0);

        // First fault from UP, then 8-tick back-off
        seq_state = 4'hA;
        wait_fault(10, n);
        check("f1_latency", 32'(n), 32'd4);
        check("f1_state", 32'(sup_state), 32'd4);
        check("f1_retry", 32'(retry_count), 32'd1);
        check("f1_se", 32'(seq_enable), 32'd0);
        seq_state = 4'h0;
        step();
        check("f1_pulse_width", 32'(fault), 32'd0);
        wait_se(80, n);
        check_range("f1_backoff_cycles", n + 1, 30, 33);
        check("f1_rebooting", 32'(sup_state), 32'd2);

        // Second fault doubles the back-off
        seq_state = 4'hA;
        wait_fault(10, n);
        check("f2_retry", 32'(retry_count), 32'd2);
        seq_state = 4'h0;
        wait_se(100, n);
        check_range("f2_backoff_cycles", n, 62, 65);

        // Stable UP for 20 ticks clears the count
        seq_state = 4'h9;
        repeat (4) step();
        check("st_state_up", 32'(sup_state), 32'd3);
        check("st_retry_held", 32'(retry_count), 32'd2);
        repeat (77) step();
        check("st_retry_before", 32'(retry_count), 32'd2);
        repeat (4) step();
        check("st_retry_cleared", 32'(retry_count), 32'd0);

        // One-cycle glitch is filtered
        fc0 = fault_cnt;
        seq_state = 4'hB;
        step();
        seq_state = 4'h9;
        repeat (6) step();
        check("glitch_no_fault", 32'(fault_cnt - fc0), 32'd0);
        check("glitch_state", 32'(sup_state), 32'd3);

        // Host withdraw from UP, then boot timeout at 50 ticks
        host_enable = 1'b0;
        seq_state = 4'h1;
        step();
        check("wd_state_idle", 32'(sup_state), 32'd1);
        check("wd_se", 32'(seq_enable), 32'd0);
        repeat (3) step();
        host_enable = 1'b1;
        step();
        check("to_state_boot", 32'(sup_state), 32'd2);
        wait_fault(300, n);
        check_range("to_fault_cycles", n, 198, 201);
        check("to_retry", 32'(retry_count), 32'd1);
        check("to_state", 32'(sup_state), 32'd4);

        // Three more faults: last one locks out
        for (int k = 2; k <= 4; k++) begin
            seq_state = 4'h0;
            wait_se(300, n);
            check_range("lk_backoff_done", n, 1, 300);
            seq_state = 4'hA;
            wait_fault(10, n);
            check("lk_fault_latency", 32'(n), 32'd4);
            check("lk_retry", 32'(retry_count), (k < 4) ? 32'(k) : 32'd3);
        end
        check("lk_locked", 32'(locked_out), 32'd1);
        check("lk_state", 32'(sup_state), 32'd5);
        check("lk_se", 32'(seq_enable), 32'd0);

        // Release by withdrawing and re-asserting host request
        seq_state = 4'h0;
        host_enable = 1'b0;
        step();
        check("rel_state_idle", 32'(sup_state), 32'd1);
        check("rel_retry", 32'(retry_count), 32'd0);
        check("rel_locked", 32'(locked_out), 32'd0);
        repeat (3) step();
        host_enable = 1'b1;
        step();
        check("rel_state_boot", 32'(sup_state), 32'd2);
        check("rel_se", 32'(seq_enable), 32'd1);

        // Asynchronous reset from UP
        seq_state = 4'h9;
        repeat (4) step();
        check("ar_state_up", 32'(sup_state), 32'd3);
        @(posedge sysclk);
        #2;
        reset = 1'b1;
        #1;
        check("ar_se_async", 32'(seq_enable), 32'd0);
        check("ar_state", 32'(sup_state), 32'd0);
        step();
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
